multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32 datapath: the control unit for the multi-cycle variant of the `cpu` core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes:

- instruction-register load
- register-file write
- data-memory read/write
- ALU operand select
- PC update

It waits on a data-memory ready handshake, counts retired instructions, and stops in a sticky HALT state on an illegal opcode or a memory timeout.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/mem_wait_timer.sv | 26 ++
 rtl/multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32 control unit: opcodes, FSM states,
// ALUOp and PCSrc selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic PCSRC_SEQ    = 1'b0;
  localparam logic PCSRC_BRANCH = 1'b1;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle. master = control unit, slave = datapath.
interface multicycle_ctrl_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alu_zero;
  logic        mem_ready;
  logic        IRWrite;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        halted;
  logic        error;

  modport master (
    input  opcode, funct3, alu_zero, mem_ready,
    output IRWrite, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite,
           PCWrite, PCSrc, state, instret, halted, error
  );

  modport slave (
    output opcode, funct3, alu_zero, mem_ready,
    input  IRWrite, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite,
           PCWrite, PCSrc, state, instret, halted, error
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts MEM cycles without mem_ready; timeout flags the last allowed wait cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic mem_ready,
  output logic timeout
);

  localparam int W = $clog2(MEM_TIMEOUT) + 1;

  logic [W-1:0] cnt;

  assign timeout = (cnt == W'(MEM_TIMEOUT - 1));

  // Saturates at the terminal value; the FSM leaves MEM on that cycle anyway.
  always_ff @(posedge clk) begin
    if (rst || clear)
      cnt <= '0;
    else if (!mem_ready && !timeout)
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencer: steps FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
//   state  | meaning
//   FETCH  | load instruction register
//   DECODE | latch opcode/funct3, reject illegal opcodes
//   EXEC   | ALU op; branches resolve and retire here
//   MEM    | data access, waits on mem_ready with timeout
//   WB     | register write-back, retire
//   HALT   | sticky stop until rst
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  state_t      state_q;
  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic [31:0] instret_q;
  logic        error_q;
  logic        timeout;
  logic        br_f3_ok;
  logic        br_taken;

  logic        ir_write, alu_src, mem_read, mem_write, mem_to_reg;
  logic        reg_write, pc_write, pc_src;
  logic [1:0]  alu_op;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q != S_MEM),
    .mem_ready (bus.mem_ready),
    .timeout   (timeout)
  );

  assign br_f3_ok = (f3_q == F3_BEQ) || (f3_q == F3_BNE);
  assign br_taken = (f3_q == F3_BEQ) ? bus.alu_zero : !bus.alu_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      instret_q <= '0;
      error_q   <= 1'b0;
    end else begin
      if (pc_write)
        instret_q <= instret_q + 32'd1;
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          op_q <= bus.opcode;
          f3_q <= bus.funct3;
          if (op_legal(bus.opcode)) begin
            state_q <= S_EXEC;
          end else begin
            state_q <= S_HALT;
            error_q <= 1'b1;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_R, OP_I:        state_q <= S_WB;
            OP_LOAD, OP_STORE: state_q <= S_MEM;
            OP_BRANCH: begin
              if (br_f3_ok) begin
                state_q <= S_FETCH;
              end else begin
                state_q <= S_HALT;
                error_q <= 1'b1;
              end
            end
            default: begin
              state_q <= S_HALT;
              error_q <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          // A late mem_ready on the timeout cycle still completes the access.
          if (bus.mem_ready) begin
            state_q <= (op_q == OP_LOAD) ? S_WB : S_FETCH;
          end else if (timeout) begin
            state_q <= S_HALT;
            error_q <= 1'b1;
          end
        end
        S_WB:    state_q <= S_FETCH;
        S_HALT:  state_q <= S_HALT;
        default: begin
          state_q <= S_HALT;
          error_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PCSRC_SEQ;
    case (state_q)
      S_FETCH: ir_write = 1'b1;
      S_EXEC: begin
        case (op_q)
          OP_R: alu_op = ALUOP_RTYPE;
          OP_I: begin
            alu_op  = ALUOP_ITYPE;
            alu_src = 1'b1;
          end
          OP_LOAD, OP_STORE: alu_src = 1'b1;
          OP_BRANCH: begin
            alu_op   = ALUOP_SUB;
            pc_write = br_f3_ok;
            pc_src   = br_f3_ok ? (br_taken ? PCSRC_BRANCH : PCSRC_SEQ) : PCSRC_SEQ;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        alu_src   = 1'b1;
        mem_read  = (op_q == OP_LOAD);
        mem_write = (op_q == OP_STORE);
        pc_write  = (op_q == OP_STORE) && bus.mem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        pc_write   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.IRWrite  = ir_write;
  assign bus.ALUSrc   = alu_src;
  assign bus.ALUOp    = alu_op;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.RegWrite = reg_write;
  assign bus.PCWrite  = pc_write;
  assign bus.PCSrc    = pc_src;
  assign bus.state    = state_q;
  assign bus.instret  = instret_q;
  assign bus.halted   = (state_q == S_HALT);
  assign bus.error    = error_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction classes, waits, timeout, halt and reset.
module tb_multicycle_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.opcode    = OP_R;
    bus.funct3    = 3'b000;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b1;
    step; step;
    check_val("rst_state",   32'(bus.state), 0);
    check_val("rst_instret", bus.instret, 0);
    check_val("rst_irwrite", 32'(bus.IRWrite), 1);
    check_val("rst_regwr",   32'(bus.RegWrite), 0);
    check_val("rst_pcwr",    32'(bus.PCWrite), 0);
    check_val("rst_memwr",   32'(bus.MemWrite), 0);
    check_val("rst_halted",  32'(bus.halted), 0);
    check_val("rst_error",   32'(bus.error), 0);
    rst = 1'b0;

    // R-type: 0,1,2,4,0
    step;
    check_val("r_dec_state", 32'(bus.state), 1);
    check_val("r_dec_ir",    32'(bus.IRWrite), 0);
    step;
    check_val("r_exec_state", 32'(bus.state), 2);
    check_val("r_exec_aluop", 32'(bus.ALUOp), 2);
    check_val("r_exec_src",   32'(bus.ALUSrc), 0);
    check_val("r_exec_regwr", 32'(bus.RegWrite), 0);
    bus.opcode = 7'h7f;
    #1;
    check_val("r_latched_aluop", 32'(bus.ALUOp), 2);
    step;
    check_val("r_wb_state", 32'(bus.state), 4);
    check_val("r_wb_regwr", 32'(bus.RegWrite), 1);
    check_val("r_wb_m2r",   32'(bus.MemtoReg), 0);
    check_val("r_wb_pcwr",  32'(bus.PCWrite), 1);
    check_val("r_wb_inst",  bus.instret, 0);
    step;
    check_val("r_done_state", 32'(bus.state), 0);
    check_val("r_done_inst",  bus.instret, 1);

    // LOAD: three wait cycles then ready
    bus.opcode    = OP_LOAD;
    bus.mem_ready = 1'b0;
    step; step;
    check_val("ld_exec_aluop", 32'(bus.ALUOp), 0);
    check_val("ld_exec_src",   32'(bus.ALUSrc), 1);
    step;
    cnt = 0;
    for (int i = 0; i < 10 && bus.state == 3'd3; i++) begin
      if (bus.MemRead) cnt++;
      if (i == 3) bus.mem_ready = 1'b1;
      step;
    end
    check_val("ld_memread_cycles", cnt, 4);
    check_val("ld_wb_state", 32'(bus.state), 4);
    check_val("ld_wb_m2r",   32'(bus.MemtoReg), 1);
    check_val("ld_wb_regwr", 32'(bus.RegWrite), 1);
    check_val("ld_wb_mrd",   32'(bus.MemRead), 0);
    step;
    check_val("ld_done_state", 32'(bus.state), 0);
    check_val("ld_done_inst",  bus.instret, 2);

    // STORE, ready on entry: PCWrite follows mem_ready combinationally
    bus.opcode = OP_STORE;
    step; step; step;
    check_val("st_mem_state", 32'(bus.state), 3);
    check_val("st_memwr",     32'(bus.MemWrite), 1);
    check_val("st_pcwr",      32'(bus.PCWrite), 1);
    check_val("st_pcsrc",     32'(bus.PCSrc), 0);
    bus.mem_ready = 1'b0;
    #1;
    check_val("st_pcwr_noready", 32'(bus.PCWrite), 0);
    bus.mem_ready = 1'b1;
    #1;
    step;
    check_val("st_done_state", 32'(bus.state), 0);
    check_val("st_done_inst",  bus.instret, 3);

    // beq taken
    bus.opcode   = OP_BRANCH;
    bus.funct3   = 3'b000;
    bus.alu_zero = 1'b1;
    step; step;
    check_val("beq_state", 32'(bus.state), 2);
    check_val("beq_aluop", 32'(bus.ALUOp), 1);
    check_val("beq_pcwr",  32'(bus.PCWrite), 1);
    check_val("beq_pcsrc", 32'(bus.PCSrc), 1);
    bus.alu_zero = 1'b0;
    #1;
    check_val("beq_nt_pcsrc", 32'(bus.PCSrc), 0);
    bus.alu_zero = 1'b1;
    step;
    check_val("beq_done_state", 32'(bus.state), 0);
    check_val("beq_done_inst",  bus.instret, 4);

    // bne with alu_zero=1: not taken
    bus.funct3 = 3'b001;
    step; step;
    check_val("bne_pcwr",  32'(bus.PCWrite), 1);
    check_val("bne_pcsrc", 32'(bus.PCSrc), 0);
    step;
    check_val("bne_done_inst", bus.instret, 5);

    // STORE timeout
    bus.opcode    = OP_STORE;
    bus.mem_ready = 1'b0;
    step; step; step;
    cnt = 0;
    for (int i = 0; i < 40 && bus.state == 3'd3; i++) begin
      if (bus.MemWrite) cnt++;
      step;
    end
    check_val("to_memwr_cycles", cnt, 16);
    check_val("to_state",   32'(bus.state), 5);
    check_val("to_halted",  32'(bus.halted), 1);
    check_val("to_error",   32'(bus.error), 1);
    check_val("to_instret", bus.instret, 5);
    check_val("to_memwr",   32'(bus.MemWrite), 0);

    rst = 1'b1;
    step;
    rst = 1'b0;
    check_val("rst2_state", 32'(bus.state), 0);
    check_val("rst2_inst",  bus.instret, 0);
    check_val("rst2_error", 32'(bus.error), 0);

    // Illegal opcode: sticky HALT
    bus.opcode = 7'b1111111;
    step; step;
    check_val("ill_state",  32'(bus.state), 5);
    check_val("ill_error",  32'(bus.error), 1);
    check_val("ill_halted", 32'(bus.halted), 1);
    check_val("ill_irwr",   32'(bus.IRWrite), 0);
    bus.opcode = OP_R;
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = i[0];
      step;
      check_val("ill_hold_state", 32'(bus.state), 5);
      check_val("ill_hold_pcwr",  32'(bus.PCWrite), 0);
    end
    check_val("ill_inst", bus.instret, 0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check_val("rst3_state", 32'(bus.state), 0);
    check_val("rst3_error", 32'(bus.error), 0);

    // Branch with unsupported funct3
    bus.mem_ready = 1'b1;
    bus.opcode    = OP_BRANCH;
    bus.funct3    = 3'b010;
    step; step;
    check_val("bbad_pcwr", 32'(bus.PCWrite), 0);
    step;
    check_val("bbad_state", 32'(bus.state), 5);
    check_val("bbad_error", 32'(bus.error), 1);
    check_val("bbad_inst",  bus.instret, 0);
    rst = 1'b1;
    step;
    rst = 1'b0;

    // Reset in the middle of a STORE wait
    bus.opcode = OP_R;
    step; step; step; step;
    check_val("pre_inst", bus.instret, 1);
    bus.opcode    = OP_STORE;
    bus.mem_ready = 1'b0;
    step; step; step; step; step;
    check_val("mid_state", 32'(bus.state), 3);
    check_val("mid_memwr", 32'(bus.MemWrite), 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check_val("mid_rst_memwr", 32'(bus.MemWrite), 0);
    check_val("mid_rst_state", 32'(bus.state), 0);
    check_val("mid_rst_inst",  bus.instret, 0);
    step;
    check_val("mid_after_state", 32'(bus.state), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
